button_events: RTL and testbench
================================

Name: button_events

Overview:
- Multi-channel push-button event classifier. It turns N raw active-low key inputs into debounced levels and one-cycle event pulses: SHORT, LONG, DOUBLE and REPEAT.
- It sits between the board key pins and the control/menu logic.
- It replaces the single-key short/long decoder with per-channel debounce, a double-click window and auto-repeat while held.

Parameters:
- N_KEYS, 4, number of independent key channels.
- CNT_W, 28, width of every per-channel counter; must hold the largest cycle parameter.
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles before the debounced level changes (20 ms at 50 MHz).
- LONG_CYC, 50_000_000, debounced hold cycles that classify a press as LONG (1 s).
- DCLICK_CYC, 15_000_000, maximum release gap that turns a second press into DOUBLE; 0 disables double-click detection.
- REPEAT_CYC, 10_000_000, REPEAT period after LONG while still held.
- REPEAT_EN, 1, 1 enables REPEAT events, 0 suppresses them.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key  in  N_KEYS  raw key pins, active low (0 = pressed), asynchronous to CLOCK_50.
- pressed  out  N_KEYS  debounced level per channel, 1 = held.
- evt_valid  out  N_KEYS  one-cycle event strobe per channel.
- evt_code  out  3*N_KEYS  event code per channel; bits [3i+2:3i] belong to channel i.

Behaviour:
- Reset values:
  - Synchronisers are 1 (released).
  - pressed = 0, evt_valid = 0, evt_code = 0.
  - All counters are 0 and every FSM is in IDLE.
- Event codes: 0 NONE, 1 SHORT, 2 LONG, 3 DOUBLE, 4 REPEAT. evt_code[i] is nonzero only in the cycle where evt_valid[i] = 1; otherwise it is 0.
- Channels are fully independent. Simultaneous events on different channels in the same cycle are all reported. A channel produces at most one event per cycle.
- Synchroniser: a 2-FF chain per key. All downstream logic uses the second flop.
- Debounce:
  - The counter increments while the synchronised level differs from the current debounced level. It clears to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYC, the debounced level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYC has no effect.
  - Latency from a key edge to the pressed edge is DEBOUNCE_CYC + 2 cycles.
- FSM per channel (states IDLE, PRESS1, GAP, PRESS2, HOLD):
  - IDLE: a debounced press edge loads hold_cnt = 0 and moves to PRESS1.
  - PRESS1:
    - hold_cnt increments each cycle.
    - When hold_cnt reaches LONG_CYC: emit LONG, clear rep_cnt, move to HOLD.
    - On a debounced release before LONG_CYC: if DCLICK_CYC = 0, emit SHORT and move to IDLE; otherwise clear gap_cnt and move to GAP.
  - GAP:
    - gap_cnt increments each cycle.
    - A debounced press edge while gap_cnt < DCLICK_CYC moves to PRESS2.
    - When gap_cnt reaches DCLICK_CYC: emit SHORT and move to IDLE.
    - If a press edge and the timeout occur in the same cycle, the press wins (no SHORT; move to PRESS2).
  - PRESS2: on a debounced release, emit DOUBLE and move to IDLE, regardless of hold length. LONG is never emitted from PRESS2.
  - HOLD:
    - If REPEAT_EN = 1: rep_cnt increments each cycle; when it reaches REPEAT_CYC, emit REPEAT and clear rep_cnt.
    - On a debounced release: move to IDLE with no event.
    - If a REPEAT and the release fall in the same cycle, REPEAT is emitted.
- Counters saturate at their all-ones value and never wrap. A key held indefinitely keeps repeating and never produces a spurious event.
- Event timing: evt_valid is registered and asserts the cycle after the FSM condition is detected.
- Reset mid-operation:
  - Everything returns to reset values immediately, including any pending GAP (no SHORT is emitted).
  - A key still held when rst_n deasserts is treated as a new press: pressed rises DEBOUNCE_CYC + 2 cycles later, and LONG timing starts from that edge.

Test Plan:
(Bench parameters: N_KEYS = 2, DEBOUNCE_CYC = 4, LONG_CYC = 40, DCLICK_CYC = 20, REPEAT_CYC = 10, REPEAT_EN = 1.)
- Glitch rejection: key[0] low for 3 cycles, then high -> pressed[0] stays 0 and evt_valid stays 0 for 100 cycles.
- Short press: key[0] low for 15 cycles, then high -> pressed[0] is high for 15 cycles; exactly one SHORT (code 1) about 20 cycles after pressed falls; no other event.
- Double click: low 10, high 8, low 10, high -> exactly one DOUBLE (code 3), emitted after the second debounced release; no SHORT.
- Long plus repeat: key[1] held for 85 debounced cycles -> LONG (code 2) at hold cycle 40; REPEAT (code 4) at 50, 60, 70, 80; no event on release. Repeat with REPEAT_EN = 0 -> LONG only.
- Concurrency: key[0] short press and key[1] long press overlapping, with both edges in the same cycle -> each channel reports its own sequence, unaffected by the other.
- Reset mid-hold: assert rst_n low at hold cycle 30 of key[0] while the key stays held -> all outputs 0 during reset; after release of reset, pressed[0] rises 6 cycles later and LONG arrives 40 cycles after that.

Source files
------------

// File: rtl/button_events.sv
// Multi-channel push-button classifier: 2-FF sync, debounce and a per-key
// FSM that reports SHORT / LONG / DOUBLE / REPEAT as one-cycle strobes.
`timescale 1ns/1ps
module button_events #(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned CNT_W        = 28,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned LONG_CYC     = 50_000_000,
    parameter int unsigned DCLICK_CYC   = 15_000_000,
    parameter int unsigned REPEAT_CYC   = 10_000_000,
    parameter int unsigned REPEAT_EN    = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic [N_KEYS-1:0]     key,
    output logic [N_KEYS-1:0]     pressed,
    output logic [N_KEYS-1:0]     evt_valid,
    output logic [3*N_KEYS-1:0]   evt_code
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam logic [2:0] EV_NONE   = 3'd0;
    localparam logic [2:0] EV_SHORT  = 3'd1;
    localparam logic [2:0] EV_LONG   = 3'd2;
    localparam logic [2:0] EV_DOUBLE = 3'd3;
    localparam logic [2:0] EV_REPEAT = 3'd4;

    localparam logic [CNT_W-1:0] DEB_LIM    = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] DCLICK_LIM = CNT_W'(DCLICK_CYC);
    localparam logic [CNT_W-1:0] REP_LIM    = CNT_W'(REPEAT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic             sync1, sync2;
        logic             level;
        logic [CNT_W-1:0] db_cnt;
        logic [CNT_W-1:0] db_inc_c;
        logic             differ_c, flip_c, press_c, release_c;

        logic [2:0]       state, state_nxt;
        logic [CNT_W-1:0] hold_cnt, hold_nxt, hold_inc_c;
        logic [CNT_W-1:0] gap_cnt, gap_nxt, gap_inc_c;
        logic [CNT_W-1:0] rep_cnt, rep_nxt, rep_inc_c;
        logic [2:0]       ev_nxt;
        logic             ev_valid_q;
        logic [2:0]       ev_code_q;

        // Debounced level flips on the cycle the mismatch count reaches the limit.
        assign differ_c  = (~sync2) != level;
        assign db_inc_c  = sat_inc(db_cnt);
        assign flip_c    = differ_c && (db_inc_c >= DEB_LIM);
        assign press_c   = flip_c && !level;
        assign release_c = flip_c && level;

        always_ff @(posedge CLOCK_50 or negedge rst_n) begin
            if (!rst_n) begin
                sync1  <= 1'b1;
                sync2  <= 1'b1;
                level  <= 1'b0;
                db_cnt <= '0;
            end else begin
                sync1 <= key[g];
                sync2 <= sync1;
                if (!differ_c || flip_c) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_inc_c;
                end
                if (flip_c) begin
                    level <= ~level;
                end
            end
        end

        assign hold_inc_c = sat_inc(hold_cnt);
        assign gap_inc_c  = sat_inc(gap_cnt);
        assign rep_inc_c  = sat_inc(rep_cnt);

        // Classifier next-state and event decode.
        always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            gap_nxt   = gap_cnt;
            rep_nxt   = rep_cnt;
            ev_nxt    = EV_NONE;
            case (state)
                ST_IDLE: begin
                    if (press_c) begin
                        hold_nxt  = '0;
                        state_nxt = ST_PRESS1;
                    end
                end
                ST_PRESS1: begin
                    hold_nxt = hold_inc_c;
                    if (hold_inc_c == LONG_LIM) begin
                        ev_nxt    = EV_LONG;
                        rep_nxt   = '0;
                        state_nxt = release_c ? ST_IDLE : ST_HOLD;
                    end else if (release_c) begin
                        if (DCLICK_CYC == 0) begin
                            ev_nxt    = EV_SHORT;
                            state_nxt = ST_IDLE;
                        end else begin
                            gap_nxt   = '0;
                            state_nxt = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    gap_nxt = gap_inc_c;
                    if (press_c && (gap_cnt < DCLICK_LIM)) begin
                        state_nxt = ST_PRESS2;
                    end else if (gap_inc_c == DCLICK_LIM) begin
                        ev_nxt    = EV_SHORT;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_PRESS2: begin
                    if (release_c) begin
                        ev_nxt    = EV_DOUBLE;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (REPEAT_EN != 0) begin
                        rep_nxt = rep_inc_c;
                        if (rep_inc_c == REP_LIM) begin
                            ev_nxt  = EV_REPEAT;
                            rep_nxt = '0;
                        end
                    end
                    if (release_c) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge CLOCK_50 or negedge rst_n) begin
            if (!rst_n) begin
                state      <= ST_IDLE;
                hold_cnt   <= '0;
                gap_cnt    <= '0;
                rep_cnt    <= '0;
                ev_valid_q <= 1'b0;
                ev_code_q  <= EV_NONE;
            end else begin
                state      <= state_nxt;
                hold_cnt   <= hold_nxt;
                gap_cnt    <= gap_nxt;
                rep_cnt    <= rep_nxt;
                ev_valid_q <= ev_nxt != EV_NONE;
                ev_code_q  <= ev_nxt;
            end
        end

        assign pressed[g]          = level;
        assign evt_valid[g]        = ev_valid_q;
        assign evt_code[3*g +: 3]  = ev_code_q;
    end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with small cycle parameters; events are
// logged with their cycle stamp and compared against hand-computed timing.
`timescale 1ns/1ps
module tb_button_events;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic [1:0] key;
    logic [1:0] pressed, evt_valid;
    logic [5:0] evt_code;
    logic [1:0] pressed_nr, evt_valid_nr;
    logic [5:0] evt_code_nr;

    button_events #(.N_KEYS(2), .DEBOUNCE_CYC(4), .LONG_CYC(40), .DCLICK_CYC(20),
                    .REPEAT_CYC(10), .REPEAT_EN(1)) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .key(key),
        .pressed(pressed), .evt_valid(evt_valid), .evt_code(evt_code));

    button_events #(.N_KEYS(2), .DEBOUNCE_CYC(4), .LONG_CYC(40), .DCLICK_CYC(20),
                    .REPEAT_CYC(10), .REPEAT_EN(0)) dut_nr (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .key(key),
        .pressed(pressed_nr), .evt_valid(evt_valid_nr), .evt_code(evt_code_nr));

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int ch;
        int code;
        int cyc;
    } ev_t;

    ev_t evq[$];
    ev_t evq_nr[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  bad_code = 0;
    int  hi_cnt[2];
    int  rise_cyc[2];
    logic [1:0] prev_p = 2'b00;
    int  exp_code[5];
    int  exp_cyc[5];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Event logger sampled on the falling edge.
    always @(negedge CLOCK_50) begin
        ev_t e;
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                if (evt_valid[c]) begin
                    e.ch = c; e.code = int'(evt_code[3*c +: 3]); e.cyc = cyc;
                    evq.push_back(e);
                end else if (evt_code[3*c +: 3] != 3'd0) begin
                    bad_code++;
                end
                if (evt_valid_nr[c]) begin
                    e.ch = c; e.code = int'(evt_code_nr[3*c +: 3]); e.cyc = cyc;
                    evq_nr.push_back(e);
                end
                if (pressed[c]) hi_cnt[c]++;
                if (pressed[c] && !prev_p[c] && rise_cyc[c] < 0) rise_cyc[c] = cyc;
            end
            prev_p = pressed;
        end else begin
            prev_p = 2'b00;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_log();
        evq.delete();
        evq_nr.delete();
        for (int c = 0; c < 2; c++) begin
            hi_cnt[c]   = 0;
            rise_cyc[c] = -1;
        end
    endtask

    // Compares the logged events of one channel against exp_code/exp_cyc.
    task automatic check_events(input string tag, input int ch, input bit nr, input int n);
        int idx = 0;
        int total;
        ev_t e;
        total = nr ? evq_nr.size() : evq.size();
        for (int i = 0; i < total; i++) begin
            e = nr ? evq_nr[i] : evq[i];
            if (e.ch == ch) begin
                if (idx < n && idx < 5) begin
                    check($sformatf("%s_code%0d", tag, idx), e.code, exp_code[idx]);
                    check($sformatf("%s_cyc%0d", tag, idx), e.cyc, exp_cyc[idx]);
                end
                idx++;
            end
        end
        check({tag, "_count"}, idx, n);
    endtask

    initial begin
        int k0;
        rst_n = 1'b0;
        key   = 2'b11;
        clear_log();
        step(3);
        check("rst_pressed", int'(pressed), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_code", int'(evt_code), 0);
        rst_n = 1'b1;
        step(10);

        // Glitch of 3 cycles is filtered.
        clear_log();
        k0 = cyc;
        key[0] = 1'b0;
        step(3);
        key[0] = 1'b1;
        step(100);
        check("glitch_pressed", hi_cnt[0], 0);
        check_events("glitch_ev", 0, 1'b0, 0);

        // Short press.
        clear_log();
        k0 = cyc;
        key[0] = 1'b0;
        step(15);
        key[0] = 1'b1;
        step(90);
        check("short_rise", rise_cyc[0], k0 + 6);
        check("short_hi", hi_cnt[0], 15);
        exp_code[0] = 1; exp_cyc[0] = k0 + 41;
        check_events("short_ev", 0, 1'b0, 1);

        // Double click.
        clear_log();
        k0 = cyc;
        key[0] = 1'b0;
        step(10);
        key[0] = 1'b1;
        step(8);
        key[0] = 1'b0;
        step(10);
        key[0] = 1'b1;
        step(80);
        exp_code[0] = 3; exp_cyc[0] = k0 + 34;
        check_events("double_ev", 0, 1'b0, 1);

        // Long press with repeats, and the repeat-disabled instance.
        clear_log();
        k0 = cyc;
        key[1] = 1'b0;
        step(85);
        key[1] = 1'b1;
        step(60);
        check("long_hi", hi_cnt[1], 85);
        exp_code = '{2, 4, 4, 4, 4};
        exp_cyc  = '{k0 + 46, k0 + 56, k0 + 66, k0 + 76, k0 + 86};
        check_events("long_ev", 1, 1'b0, 5);
        exp_code[0] = 2; exp_cyc[0] = k0 + 46;
        check_events("norep_ev", 1, 1'b1, 1);

        // Concurrent short on key0 and long on key1.
        clear_log();
        k0 = cyc;
        key = 2'b00;
        step(15);
        key[0] = 1'b1;
        step(70);
        key[1] = 1'b1;
        step(60);
        exp_code[0] = 1; exp_cyc[0] = k0 + 41;
        check_events("conc_ch0", 0, 1'b0, 1);
        exp_code = '{2, 4, 4, 4, 4};
        exp_cyc  = '{k0 + 46, k0 + 56, k0 + 66, k0 + 76, k0 + 86};
        check_events("conc_ch1", 1, 1'b0, 5);

        // Reset during a hold; key stays held across reset release.
        clear_log();
        k0 = cyc;
        key[0] = 1'b0;
        step(36);
        rst_n = 1'b0;
        #1;
        check("midrst_pressed", int'(pressed), 0);
        check("midrst_valid", int'(evt_valid), 0);
        check("midrst_code", int'(evt_code), 0);
        step(3);
        check("midrst_pressed2", int'(pressed), 0);
        clear_log();
        step(1);
        k0 = cyc;
        rst_n = 1'b1;
        step(50);
        check("postrst_rise", rise_cyc[0], k0 + 6);
        exp_code[0] = 2; exp_cyc[0] = k0 + 46;
        check_events("postrst_ev", 0, 1'b0, 1);
        key[0] = 1'b1;
        step(30);

        check("code_idle_zero", bad_code, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
